// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control
//
// Control FSM for a one-cycle, direct-mapped, write-back cache. It resolves
// CPU hits in the request cycle. On a miss it runs an optional writeback of
// the victim line, then a line fill, on the physical-memory port. After the
// fill the FSM returns to IDLE, where the still-held request hits and
// completes.
//
// Optional feature: define CACHE_CTRL_PERF_EN to build hit/miss/writeback
// performance counters. Without it, the counter ports read constant 0 and
// no counter flops exist.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset; forces IDLE and zeroes outputs
//   mem_read     CPU read request, held until mem_resp
//   mem_write    CPU write request, held until mem_resp (wins over mem_read)
//   hit          datapath tag match AND valid for the requested index
//   dirty        dirty bit of the indexed line
//   pmem_resp    physical-memory transaction complete (one-cycle pulse)
//   mem_resp     CPU request complete
//   pmem_read    line fill request
//   pmem_write   line writeback request
//   load_tag     tag array write enable
//   load_valid   valid array write enable (valid datain is constant 1)
//   load_dirty   dirty array write enable
//   dirty_in     dirty array datain
//   load_data    data array write enable
//   data_sel     data source: 0 = CPU write data, 1 = pmem line
//   addr_sel     pmem address source: 0 = {CPU tag, index}, 1 = {stored tag, index}
//   hit_count    requests completed as hits (CNT_W, wraps)
//   miss_count   requests that missed (CNT_W, wraps)
//   wb_count     writebacks issued (CNT_W, wraps)
// ---------------------------------------------------------------------------
module cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit,
    input  logic             dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             load_tag,
    output logic             load_valid,
    output logic             load_dirty,
    output logic             dirty_in,
    output logic             load_data,
    output logic             data_sel,
    output logic             addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FILL      = 2'd2;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       request;

    assign request = mem_read | mem_write;

    // Output decode and next-state logic. Every output is gated by rst so
    // nothing (in particular no array write enable) escapes while the FSM
    // is being held in reset, even if a request is present.
    always_comb begin
        state_next = state_reg;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_tag   = 1'b0;
        load_valid = 1'b0;
        load_dirty = 1'b0;
        dirty_in   = 1'b0;
        load_data  = 1'b0;
        data_sel   = 1'b0;
        addr_sel   = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (request) begin
                        if (hit) begin
                            mem_resp = 1'b1;
                            // A write (including read+write) merges CPU data
                            // into the line and marks it dirty.
                            if (mem_write) begin
                                load_data  = 1'b1;
                                data_sel   = 1'b0;
                                load_dirty = 1'b1;
                                dirty_in   = 1'b1;
                            end
                        end else begin
                            state_next = dirty ? WRITEBACK : FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = 1'b1;
                    if (pmem_resp) begin
                        state_next = FILL;
                    end
                end
                FILL: begin
                    pmem_read = 1'b1;
                    addr_sel  = 1'b0;
                    if (pmem_resp) begin
                        // Install the fetched line clean; a pending write
                        // dirties it when it hits back in IDLE.
                        load_data  = 1'b1;
                        data_sel   = 1'b1;
                        load_tag   = 1'b1;
                        load_valid = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b0;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    // was_miss marks that the request now being serviced already counted as
    // a miss, so its post-fill completion in IDLE is not also counted as a hit.
    logic                  was_miss_reg;
    logic                  was_miss_next;
    logic                  leave_for_miss;
    logic                  wb_done;
    logic [2:0]            cnt_inc;
    logic [2:0][CNT_W-1:0] cnt_all;

    // state_next only differs from state_reg when rst is low, so these
    // strobes are already quiet during reset.
    assign leave_for_miss = (state_reg == IDLE) && (state_next != IDLE);
    assign wb_done        = (state_reg == WRITEBACK) && (state_next == FILL);

    assign cnt_inc[0] = mem_resp && !was_miss_reg;
    assign cnt_inc[1] = leave_for_miss;
    assign cnt_inc[2] = wb_done;

    always_comb begin
        was_miss_next = was_miss_reg;
        if (leave_for_miss) begin
            was_miss_next = 1'b1;
        end else if (mem_resp) begin
            was_miss_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            was_miss_reg <= 1'b0;
        end else begin
            was_miss_reg <= was_miss_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (cnt_inc[gi]) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end

            assign cnt_all[gi] = count_reg;
        end
    endgenerate

    assign hit_count  = cnt_all[0];
    assign miss_count = cnt_all[1];
    assign wb_count   = cnt_all[2];
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// ---------------------------------------------------------------------------
// tb_cache_control
//
// Scoreboard bench for cache_control. The bench plays the cache datapath
// (4-line tag/valid/dirty/data arrays driven by the DUT's load strobes) and
// a physical memory with programmable writeback/fill latency. A reference
// cache model, updated per transaction, predicts hit/miss, latency, pmem
// cycle counts, the final line contents and the performance counters; the
// monitor compares those against what the DUT actually produced.
// ---------------------------------------------------------------------------
module tb_cache_control;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             mem_read;
    logic             mem_write;
    logic             hit;
    logic             dirty;
    logic             pmem_resp;
    logic             mem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic             load_tag;
    logic             load_valid;
    logic             load_dirty;
    logic             dirty_in;
    logic             load_data;
    logic             data_sel;
    logic             addr_sel;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    logic [CNT_W-1:0] wb_count;

    cache_control #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .hit        (hit),
        .dirty      (dirty),
        .pmem_resp  (pmem_resp),
        .mem_resp   (mem_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .load_dirty (load_dirty),
        .dirty_in   (dirty_in),
        .load_data  (load_data),
        .data_sel   (data_sel),
        .addr_sel   (addr_sel),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] line_pat(input logic [1:0] t, input logic [1:0] i);
        return {t, i, 4'hA};
    endfunction

    // ---------------- datapath model (driven by DUT strobes) ----------------
    logic [1:0] tag_arr   [4];
    logic       valid_arr [4];
    logic       dirty_arr [4];
    logic [7:0] data_arr  [4];
    logic [1:0] req_idx;
    logic [1:0] req_tag;
    logic [7:0] req_wdata;
    bit         init_arrays = 1'b1;

    assign hit   = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
    assign dirty = dirty_arr[req_idx];

    logic s_tag, s_valid, s_dirty, s_din, s_data, s_dsel;
    always @(negedge clk) begin
        s_tag   = load_tag;
        s_valid = load_valid;
        s_dirty = load_dirty;
        s_din   = dirty_in;
        s_data  = load_data;
        s_dsel  = data_sel;
    end

    always @(posedge clk) begin
        if (init_arrays) begin
            for (int i = 0; i < 4; i++) begin
                tag_arr[i]   <= 2'(i);
                valid_arr[i] <= 1'b1;
                dirty_arr[i] <= 1'b0;
                data_arr[i]  <= line_pat(2'(i), 2'(i));
            end
        end else if (!rst) begin
            if (s_tag)   tag_arr[req_idx]   <= req_tag;
            if (s_valid) valid_arr[req_idx] <= 1'b1;
            if (s_dirty) dirty_arr[req_idx] <= s_din;
            if (s_data)  data_arr[req_idx]  <= s_dsel ? line_pat(req_tag, req_idx) : req_wdata;
        end
    end

    // ---------------- physical memory model ----------------
    int wb_lat   = 1;
    int fill_lat = 1;
    bit stray_en = 1'b0;

    initial begin
        int cnt;
        int kind;
        int k;
        cnt = 0;
        kind = 0;
        pmem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_read || pmem_write) begin
                k = pmem_write ? 2 : 1;
                if (k != kind) cnt = 0;
                kind = k;
                cnt++;
                pmem_resp = (cnt == ((k == 2) ? wb_lat : fill_lat));
            end else begin
                cnt = 0;
                kind = 0;
                // Stray responses while idle must be ignored by the FSM.
                pmem_resp = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int         op;
        int         lat;
        int         rdc;
        int         wrc;
        logic [1:0] idx;
        logic [1:0] tag;
        logic       dirty;
        logic [7:0] data;
        int         hits;
        int         misses;
        int         wbs;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] ref_tag   [4];
    logic       ref_valid [4];
    logic       ref_dirty [4];
    logic [7:0] ref_data  [4];
    int         ref_hits   = 0;
    int         ref_misses = 0;
    int         ref_wbs    = 0;
    bit         ref_pend   = 1'b0;

    task automatic chk_counts(input string name);
`ifdef CACHE_CTRL_PERF_EN
        chk({name, "_hit_count"},  32'(hit_count),  32'(CNT_W'(ref_hits)));
        chk({name, "_miss_count"}, 32'(miss_count), 32'(CNT_W'(ref_misses)));
        chk({name, "_wb_count"},   32'(wb_count),   32'(CNT_W'(ref_wbs)));
`else
        chk({name, "_counters_tied"}, 32'({hit_count, miss_count, wb_count}), 32'd0);
`endif
    endtask

    task automatic chk_line(input string name, input logic [1:0] i);
        chk({name, "_tag"},   32'(tag_arr[i]),   32'(ref_tag[i]));
        chk({name, "_valid"}, 32'(valid_arr[i]), 32'(ref_valid[i]));
        chk({name, "_dirty"}, 32'(dirty_arr[i]), 32'(ref_dirty[i]));
        chk({name, "_data"},  32'(data_arr[i]),  32'(ref_data[i]));
    endtask

    task automatic check_zero(input string name);
        chk(name, 32'({mem_resp, pmem_read, pmem_write, load_tag, load_valid,
                       load_dirty, dirty_in, load_data, data_sel, addr_sel}), 32'd0);
    endtask

    // op: 0 = read, 1 = write, 2 = read+write (treated as write)
    task automatic do_req(input int op, input logic [1:0] i, input logic [1:0] t,
                          input logic [7:0] wd, input int wl, input int fl);
        exp_t e;
        bit   h;
        bit   got;
        h     = ref_valid[i] && (ref_tag[i] == t);
        e.op  = op;
        e.wrc = (!h && ref_dirty[i]) ? wl : 0;
        e.rdc = h ? 0 : fl;
        e.lat = h ? 0 : 1 + e.wrc + fl;
        if (h) begin
            if (ref_pend) ref_pend = 1'b0;
            else          ref_hits++;
        end else begin
            ref_misses++;
            if (ref_dirty[i]) ref_wbs++;
            ref_pend     = 1'b0;
            ref_tag[i]   = t;
            ref_valid[i] = 1'b1;
            ref_dirty[i] = 1'b0;
            ref_data[i]  = line_pat(t, i);
        end
        if (op != 0) begin
            ref_data[i]  = wd;
            ref_dirty[i] = 1'b1;
        end
        e.idx    = i;
        e.tag    = t;
        e.dirty  = ref_dirty[i];
        e.data   = ref_data[i];
        e.hits   = ref_hits;
        e.misses = ref_misses;
        e.wbs    = ref_wbs;
        sb_q.push_back(e);

        wb_lat    = wl;
        fill_lat  = fl;
        req_idx   = i;
        req_tag   = t;
        req_wdata = wd;
        mem_read  = (op != 1);
        mem_write = (op != 0);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = mem_resp;
        end
        chk("resp_within_budget", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit   active;
        int   lat;
        int   rdc;
        int   wrc;
        exp_t e;
        active = 1'b0;
        lat = 0;
        rdc = 0;
        wrc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (!(mem_read || mem_write)) begin
                    active = 1'b0;
                end else if (!active) begin
                    active = 1'b1;
                    lat = 0;
                    rdc = 0;
                    wrc = 0;
                end else begin
                    lat++;
                end
                if (pmem_read || pmem_write) begin
                    chk("pmem_exclusive", 32'(pmem_read & pmem_write), 32'd0);
                    chk("addr_sel", 32'(addr_sel), 32'(pmem_write));
                    chk("resp_outside_idle", 32'(mem_resp), 32'd0);
                    if (active) begin
                        rdc += int'(pmem_read);
                        wrc += int'(pmem_write);
                    end
                end
                if (mem_resp) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_mem_resp", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn op=%0d idx=%0d tag=%0d lat=%0d (exp %0d) rd=%0d wr=%0d",
                                 e.op, e.idx, e.tag, lat, e.lat, rdc, wrc);
                        chk("latency", 32'(lat), 32'(e.lat));
                        chk("fill_cycles", 32'(rdc), 32'(e.rdc));
                        chk("wb_cycles", 32'(wrc), 32'(e.wrc));
                        @(posedge clk);
                        #1;
                        chk("line_tag", 32'(tag_arr[e.idx]), 32'(e.tag));
                        chk("line_valid", 32'(valid_arr[e.idx]), 32'd1);
                        chk("line_dirty", 32'(dirty_arr[e.idx]), 32'(e.dirty));
                        chk("line_data", 32'(data_arr[e.idx]), 32'(e.data));
`ifdef CACHE_CTRL_PERF_EN
                        chk("txn_hit_count", 32'(hit_count), 32'(CNT_W'(e.hits)));
                        chk("txn_miss_count", 32'(miss_count), 32'(CNT_W'(e.misses)));
                        chk("txn_wb_count", 32'(wb_count), 32'(CNT_W'(e.wbs)));
`endif
                    end
                    active = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit seen_fill;
        bit seen_resp;
        bit done;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        req_idx   = 2'd1;
        req_tag   = 2'd1;
        req_wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            ref_tag[i]   = 2'(i);
            ref_valid[i] = 1'b1;
            ref_dirty[i] = 1'b0;
            ref_data[i]  = line_pat(2'(i), 2'(i));
        end
        @(posedge clk);
        #1;
        init_arrays = 1'b0;

        // Outputs stay 0 under reset even with a hitting write request.
        mem_read  = 1'b1;
        mem_write = 1'b1;
        #1;
        check_zero("outs_in_reset");
        chk_counts("reset");
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;

        do_req(0, 2'd1, 2'd1, 8'h00, 1, 1);  // read hit
        do_req(1, 2'd1, 2'd1, 8'h3C, 1, 1);  // write hit, dirties line 1
        do_req(0, 2'd2, 2'd3, 8'h00, 1, 4);  // clean read miss, 4-cycle fill
        do_req(1, 2'd1, 2'd2, 8'hC5, 3, 3);  // dirty write miss, 3 + 3
        chk_counts("after_misses");

        // Asynchronous reset in the second FILL cycle aborts the miss.
        fill_lat = 20;
        req_idx  = 2'd3;
        req_tag  = 2'd0;
        mem_read = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("fill_before_reset", 32'(pmem_read), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("outs_on_async_reset");
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        ref_hits   = 0;
        ref_misses = 0;
        ref_wbs    = 0;
        ref_pend   = 1'b0;
        chk_line("no_load_in_reset", 2'd3);
        chk_counts("reset_mid_fill");
        rst = 1'b0;
        #1;
        check_zero("idle_after_reset");
        @(posedge clk);
        #1;
        do_req(0, 2'd3, 2'd3, 8'h00, 1, 1);  // hits immediately: FSM is in IDLE

        // Request dropped during WRITEBACK: transaction still completes.
        do_req(1, 2'd0, 2'd0, 8'h5C, 1, 1);  // dirty line 0
        ref_misses++;
        ref_wbs++;
        ref_pend     = 1'b1;
        ref_tag[0]   = 2'd2;
        ref_dirty[0] = 1'b0;
        ref_data[0]  = line_pat(2'd2, 2'd0);
        wb_lat   = 3;
        fill_lat = 2;
        req_idx  = 2'd0;
        req_tag  = 2'd2;
        mem_read = 1'b1;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        seen_fill = 1'b0;
        seen_resp = 1'b0;
        done      = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (mem_resp) seen_resp = 1'b1;
            if (pmem_read) seen_fill = 1'b1;
            else if (seen_fill) done = 1'b1;
        end
        chk("drop_fill_ran", 32'(seen_fill), 32'd1);
        chk("drop_back_to_idle", 32'(done), 32'd1);
        chk("drop_no_resp", 32'(seen_resp), 32'd0);
        chk_line("drop_line", 2'd0);
        chk_counts("after_drop");
        @(posedge clk);
        #1;
        do_req(0, 2'd0, 2'd2, 8'h00, 1, 1);  // hit, not counted (was_miss pending)

        // Randomized traffic with stray pmem_resp pulses while idle.
        stray_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            do_req(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   8'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        stray_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_counts("final");
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
